// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency line memory with abortable level-held requests
module main_memory_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mem_r,
    input  logic                  mem_w,
    input  logic [31:0]           mem_addr,
    input  logic [LINE_WIDTH-1:0] mem_w_data,
    output logic [LINE_WIDTH-1:0] mem_r_data,
    output logic                  mem_ready
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  commit, c_wr;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic [LINE_WIDTH-1:0] c_data;
    logic [LINE_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH) - 1];

    logic [ADDR_WIDTH-1:0] live_idx;
    logic                  keep;
    logic                  unused_bits;

    assign live_idx    = mem_addr[ADDR_WIDTH+3:4];
    assign unused_bits = ^{mem_addr[31:ADDR_WIDTH+4], mem_addr[3:0]};
    assign keep        = (wr_q ? mem_w : mem_r) && (live_idx == idx_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        commit  = 1'b0;
        c_wr    = wr_q;
        c_idx   = idx_q;
        c_data  = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_r || mem_w) begin
                    wr_d    = mem_w;
                    idx_d   = live_idx;
                    wdata_d = mem_w_data;
                    cnt_d   = 4'd1;
                    state_d = BUSY;
                    // With single-cycle latency the acceptance edge is also the commit edge
                    if (LATENCY == 1) begin
                        commit  = 1'b1;
                        c_wr    = mem_w;
                        c_idx   = live_idx;
                        c_data  = mem_w_data;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (!keep) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == LAST) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: state_d = IDLE;
        endcase
        rdata_d = (commit && !c_wr) ? mem_q[c_idx] : rdata_q;
        ready_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && commit && c_wr)
            mem_q[c_idx] <= c_data;
    end

    assign mem_r_data = rdata_q;
    assign mem_ready  = ready_q;
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: directed checks of a LATENCY=4 and a LATENCY=1 instance
module tb_main_memory_responder;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         mem_r = 1'b0;
    logic         mem_w = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [127:0] mem_w_data = '0;
    logic [127:0] rd4, rd1;
    logic         rdy4, rdy1;
    int           compared = 0;
    int           mismatched = 0;

    localparam logic [127:0] D1 = {32'h4, 32'h3, 32'h2, 32'h1};
    localparam logic [127:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D3 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    localparam logic [127:0] D4 = 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_F0F0_F0F0;
    localparam logic [127:0] D5 = 128'h5555_AAAA_5555_AAAA_0000_FFFF_0000_FFFF;
    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] ONES = {128{1'b1}};

    always #5 clk = ~clk;

    main_memory_responder #(.ADDR_WIDTH(10), .LATENCY(4), .LINE_WIDTH(128)) u4 (
        .clk(clk), .rstn(rstn), .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_w_data(mem_w_data), .mem_r_data(rd4), .mem_ready(rdy4));

    main_memory_responder #(.ADDR_WIDTH(10), .LATENCY(1), .LINE_WIDTH(128)) u1 (
        .clk(clk), .rstn(rstn), .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_w_data(mem_w_data), .mem_r_data(rd1), .mem_ready(rdy1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until ready (bounded), drops it, and returns in the following idle cycle
    task automatic do_txn(input bit l1, input logic w, input logic r, input logic [31:0] a,
                          input logic [127:0] d, output int lat);
        mem_w = w; mem_r = r; mem_addr = a; mem_w_data = d; lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if ((l1 ? rdy1 : rdy4) === 1'b1) begin
                lat = k;
                break;
            end
        end
        mem_w = 1'b0; mem_r = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step(); step();
        compared++; if (rdy4 !== 1'b0) begin mismatched++; $display("FAIL rst_ready4 got %b want 0", rdy4); end
        compared++; if (rd4 !== '0) begin mismatched++; $display("FAIL rst_rdata4 got %h want 0", rd4); end
        compared++; if (rdy1 !== 1'b0) begin mismatched++; $display("FAIL rst_ready1 got %b want 0", rdy1); end
        compared++; if (rd1 !== '0) begin mismatched++; $display("FAIL rst_rdata1 got %h want 0", rd1); end
        rstn = 1'b1;
    endtask

    task automatic test_write_read();
        int lat;
        do_txn(0, 1, 0, 32'h40, D1, lat);
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL wr40_lat got %0d want 4", lat); end
        compared++; if (rdy4 !== 1'b0) begin mismatched++; $display("FAIL wr40_pulse got %b want 0", rdy4); end
        do_txn(0, 0, 1, 32'h40, '0, lat);
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL rd40_lat got %0d want 4", lat); end
        compared++; if (rd4 !== D1) begin mismatched++; $display("FAIL rd40_data got %h want %h", rd4, D1); end
    endtask

    task automatic test_glitch();
        int lat;
        do_txn(0, 1, 0, 32'h80, '0, lat);
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL wr80_lat got %0d want 4", lat); end
        mem_w = 1'b1; mem_addr = 32'h80; mem_w_data = ONES;
        step();
        mem_w = 1'b0;
        do_txn(0, 0, 1, 32'h80, '0, lat);
        compared++; if (lat !== 5) begin mismatched++; $display("FAIL glitch_lat got %0d want 5", lat); end
        compared++; if (rd4 !== '0) begin mismatched++; $display("FAIL glitch_data got %h want 0", rd4); end
    endtask

    task automatic test_both();
        int lat;
        do_txn(0, 1, 1, 32'h100, A5, lat);
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL both_lat got %0d want 4", lat); end
        compared++; if (rd4 !== '0) begin mismatched++; $display("FAIL both_rdata_hold got %h want 0", rd4); end
        do_txn(0, 0, 1, 32'h100, '0, lat);
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL rd100_lat got %0d want 4", lat); end
        compared++; if (rd4 !== A5) begin mismatched++; $display("FAIL rd100_data got %h want %h", rd4, A5); end
    endtask

    task automatic test_addr_change();
        int lat;
        do_txn(0, 1, 0, 32'h50, D2, lat);
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL wr50_lat got %0d want 4", lat); end
        mem_r = 1'b1; mem_addr = 32'h40;
        step();
        do_txn(0, 0, 1, 32'h50, '0, lat);
        compared++; if (lat !== 5) begin mismatched++; $display("FAIL addrchg_lat got %0d want 5", lat); end
        compared++; if (rd4 !== D2) begin mismatched++; $display("FAIL addrchg_data got %h want %h", rd4, D2); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        do_txn(0, 1, 0, 32'h200, D3, lat);
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL wr200_lat got %0d want 4", lat); end
        mem_w = 1'b1; mem_addr = 32'h200; mem_w_data = ONES;
        step(); step();
        rstn = 1'b0;
        #1;
        compared++; if (rdy4 !== 1'b0) begin mismatched++; $display("FAIL midrst_ready got %b want 0", rdy4); end
        compared++; if (rd4 !== '0) begin mismatched++; $display("FAIL midrst_rdata got %h want 0", rd4); end
        mem_w = 1'b0;
        step();
        rstn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rdy4 !== 1'b0) seen = 1'b1;
        end
        compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL midrst_noready got %b want 0", seen); end
        do_txn(0, 0, 1, 32'h200, '0, lat);
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL rd200_lat got %0d want 4", lat); end
        compared++; if (rd4 !== D3) begin mismatched++; $display("FAIL rd200_data got %h want %h", rd4, D3); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_txn(1, 0, 1, 32'h10, '0, lat);
        compared++; if (lat !== 1) begin mismatched++; $display("FAIL l1_rd10_lat got %0d want 1", lat); end
        compared++; if (rdy1 !== 1'b0) begin mismatched++; $display("FAIL l1_idle_gap got %b want 0", rdy1); end
        do_txn(1, 1, 0, 32'h20, D4, lat);
        compared++; if (lat !== 1) begin mismatched++; $display("FAIL l1_wr20_lat got %0d want 1", lat); end
        do_txn(1, 0, 1, 32'h20, '0, lat);
        compared++; if (lat !== 1) begin mismatched++; $display("FAIL l1_rd20_lat got %0d want 1", lat); end
        compared++; if (rd1 !== D4) begin mismatched++; $display("FAIL l1_rd20_data got %h want %h", rd1, D4); end
    endtask

    task automatic test_l1_glitch();
        int lat;
        mem_w = 1'b1; mem_addr = 32'h30; mem_w_data = D5;
        step();
        mem_w = 1'b0;
        compared++; if (rdy1 !== 1'b1) begin mismatched++; $display("FAIL l1_glitch_ready got %b want 1", rdy1); end
        step();
        compared++; if (rdy1 !== 1'b0) begin mismatched++; $display("FAIL l1_glitch_pulse got %b want 0", rdy1); end
        do_txn(1, 0, 1, 32'h30, '0, lat);
        compared++; if (lat !== 1) begin mismatched++; $display("FAIL l1_rd30_lat got %0d want 1", lat); end
        compared++; if (rd1 !== D5) begin mismatched++; $display("FAIL l1_rd30_data got %h want %h", rd1, D5); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_glitch();
        test_both();
        test_addr_change();
        test_reset_mid();
        test_back_to_back();
        test_l1_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
